// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP add/sub back end (normalise / round / pack).
//   EXP_W, MAN_W : exponent and stored-fraction widths of an IEEE-754 single
//   SIG_W        : width of the raw significand {carry, hidden, fraction, G, R, S}
//   EXP_MAX      : all-ones exponent (infinity encoding)
//   norm_state_t : IDLE -> NORM -> ROUND -> OUT control states
//   rne_inc()    : round-to-nearest-even increment decision
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 5;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } norm_state_t;

    // Round up when above the halfway point, or exactly halfway with an odd lsb.
    function automatic logic rne_inc(input logic g,
                                     input logic r,
                                     input logic s,
                                     input logic lsb);
        return g & (r | s | lsb);
    endfunction

endpackage

// File: rtl/unit_lzc.sv
// ---------------------------------------------------------------------------
// unit_lzc
// 27-bit combinational leading-zero counter used by the single-step
// normaliser. An all-zero input returns 27.
// Ports:
//   data_i  [26:0] in   value to scan, bit 26 is the most significant
//   count_o [4:0]  out  number of zeros above the first set bit
// ---------------------------------------------------------------------------
module unit_lzc (
    input  logic [26:0] data_i,
    output logic [4:0]  count_o
);

    logic found;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_o = 5'd27;
        found   = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && data_i[i]) begin
                count_o = 5'(26 - i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/unit_norm_round.sv
// ---------------------------------------------------------------------------
// unit_norm_round
// Back end of the FP add/sub datapath. Takes the larger biased exponent and
// the aligned add/sub significand, normalises it, rounds to nearest even and
// packs an IEEE-754 single. One operation in flight; valid/ready on both
// sides. Input fields are only sampled in IDLE.
//
// Configuration macro: NORM_LZC_EN
//   undefined : left normalisation moves one bit per cycle
//   defined   : a leading-zero count normalises in a single NORM cycle
//   Results and flags are identical in both builds; only latency differs.
//
// Ports:
//   i_clk        in   1       clock, rising edge
//   i_rst_n      in   1       synchronous reset, active-low
//   i_in_valid   in   1       upstream operand valid
//   o_in_ready   out  1       high only in IDLE
//   i_sign       in   1       result sign
//   i_exp        in   EXP_W   biased exponent (max of operands)
//   i_man        in   SIG_W   [27]=carry [26]=hidden [25:3]=fraction [2]=G [1]=R [0]=S
//   o_out_valid  out  1       o_result / o_ovf / o_unf valid
//   i_out_ready  in   1       downstream accepts the result
//   o_result     out  32      packed {sign, exp, fraction}
//   o_ovf        out  1       result is signed infinity
//   o_unf        out  1       result flushed to signed zero
// ---------------------------------------------------------------------------
module unit_norm_round
    import fpu_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [SIG_W-1:0] i_man,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_result,
    output logic             o_ovf,
    output logic             o_unf
);

    // One extra exponent bit so increments never wrap; the guards clamp.
    localparam int EXP_I_W = EXP_W + 1;

    localparam logic [EXP_I_W-1:0] EXP_ONE   = EXP_I_W'(1);
    localparam logic [EXP_I_W-1:0] EXP_MAX_I = {1'b0, EXP_MAX};

    norm_state_t        state_q,  state_d;
    logic               sign_q,   sign_d;
    logic [EXP_I_W-1:0] exp_q,    exp_d;
    logic [SIG_W-1:0]   man_q,    man_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q,    ovf_d;
    logic               unf_q,    unf_d;

    // -----------------------------------------------------------------------
    // Rounding datapath (meaningful in ROUND, where man_q[26] is set).
    // The fraction increment wraps to zero exactly when the whole
    // hidden+fraction field is ones, which is the carry out of the hidden bit.
    // -----------------------------------------------------------------------
    logic               rnd_inc;
    logic               rnd_carry;
    logic [MAN_W-1:0]   rnd_frac;
    logic [EXP_I_W-1:0] rnd_exp;

    assign rnd_inc   = rne_inc(man_q[2], man_q[1], man_q[0], man_q[3]);
    assign rnd_frac  = man_q[MAN_W+2:3] + MAN_W'(rnd_inc);
    assign rnd_carry = rnd_inc & (&man_q[MAN_W+3:3]);
    assign rnd_exp   = exp_q + EXP_I_W'(rnd_carry);

`ifdef NORM_LZC_EN
    logic [4:0]         lz;
    logic [EXP_I_W-1:0] lz_ext;

    unit_lzc u_lzc (
        .data_i  (man_q[SIG_W-2:0]),
        .count_o (lz)
    );

    assign lz_ext = EXP_I_W'(lz);
`endif

    // -----------------------------------------------------------------------
    // Next-state and datapath decisions
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        man_d    = man_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        unique case (state_q)
            IDLE: begin
                if (i_in_valid) begin
                    sign_d = i_sign;
                    exp_d  = {1'b0, i_exp};
                    man_d  = i_man;
                    if (i_exp == EXP_MAX) begin
                        // Infinite operand exponent bypasses normalisation.
                        result_d = {i_sign, EXP_MAX, {MAN_W{1'b0}}};
                        ovf_d    = 1'b1;
                        unf_d    = 1'b0;
                        state_d  = OUT;
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (man_q == '0) begin
                    // Exact cancellation: signed zero, not an underflow.
                    result_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = OUT;
                end else if (man_q[SIG_W-1]) begin
                    // Carry out: shift right, folding the lost bit into sticky.
                    man_d   = {1'b0, man_q[SIG_W-1:2], man_q[1] | man_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = ROUND;
                end else if (man_q[SIG_W-2]) begin
                    state_d = ROUND;
                end else if (exp_q <= EXP_ONE) begin
                    // No room to shift left further; denormals are not produced.
                    result_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                    state_d  = OUT;
`ifdef NORM_LZC_EN
                end else if (lz_ext < exp_q) begin
                    // Same outcome as lz single-bit steps, each of which would
                    // have seen an exponent above one.
                    man_d   = man_q << lz;
                    exp_d   = exp_q - lz_ext;
                    state_d = ROUND;
                end else begin
                    result_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                    state_d  = OUT;
                end
`else
                end else begin
                    man_d = {man_q[SIG_W-2:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                end
`endif
            end

            ROUND: begin
                if (rnd_exp >= EXP_MAX_I) begin
                    result_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
                    ovf_d    = 1'b0;
                end
                unf_d   = 1'b0;
                state_d = OUT;
            end

            OUT: begin
                // Result registers are untouched here, so they hold under stall.
                if (i_out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!i_rst_n) begin
            // NOTE: datapath registers are reset as well, not only the FSM,
            // because o_result and the flags must read zero after reset.
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            man_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign o_in_ready  = (state_q == IDLE);
    assign o_out_valid = (state_q == OUT);
    assign o_result    = result_q;
    assign o_ovf       = ovf_q;
    assign o_unf       = unf_q;

endmodule

// File: tb/tb_unit_norm_round.sv
// ---------------------------------------------------------------------------
// tb_unit_norm_round
// Self-checking bench for unit_norm_round. Expected results are pushed to a
// scoreboard queue as each operand is driven and popped when o_out_valid
// rises. Latency is the number of rising edges, counting the accept edge as
// the first, until o_out_valid is seen high. Build with NORM_LZC_EN to check
// the single-step normaliser latencies.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unit_norm_round;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic        i_sign;
    logic [7:0]  i_exp;
    logic [27:0] i_man;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_result;
    logic        o_ovf;
    logic        o_unf;

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic        unf;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] man;
        exp_t        want;
    } vec_t;

`ifdef NORM_LZC_EN
    localparam int LAT_SH3   = 3;   // three-bit left normalisation
    localparam int LAT_SH2   = 3;   // two-bit left normalisation
    localparam int LAT_SHFL  = 2;   // flush found after shifting would underflow
`else
    localparam int LAT_SH3   = 6;
    localparam int LAT_SH2   = 5;
    localparam int LAT_SHFL  = 3;
`endif

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    unit_norm_round dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_sign      (i_sign),
        .i_exp       (i_exp),
        .i_man       (i_man),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_ovf       (o_ovf),
        .o_unf       (o_unf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic vec_t mk(input string nm, input logic s, input logic [7:0] e,
                                input logic [27:0] m, input logic [31:0] res,
                                input logic ovf, input logic unf, input int lat);
        vec_t v;
        v.name = nm; v.sign = s; v.exp = e; v.man = m;
        v.want.result = res; v.want.ovf = ovf; v.want.unf = unf; v.want.lat = lat;
        return v;
    endfunction

    // Wait (bounded) for o_in_ready, present one operand for one accept edge,
    // then scramble the inputs so late sampling would be visible.
    task automatic accept_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                             output bit ok);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_in_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        ok = o_in_ready;
        if (ok) begin
            i_sign     = s;
            i_exp      = e;
            i_man      = m;
            i_in_valid = 1'b1;
            @(posedge i_clk);
            #1;
            i_in_valid = 1'b0;
            i_sign     = 1'($urandom);
            i_exp      = 8'($urandom);
            i_man      = 28'($urandom);
        end
    endtask

    // Returns at a negedge with o_out_valid high, or ok=0 after the budget.
    task automatic wait_valid(output int lat, output bit ok);
        lat = 1;
        @(negedge i_clk);
        while (!o_out_valid && lat < 64) begin
            @(posedge i_clk);
            lat++;
            @(negedge i_clk);
        end
        ok = o_out_valid;
    endtask

    task automatic release_out();
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", o_out_valid); end
        n_cmp++; if (o_result !== 32'h0) begin n_bad++; $display("FAIL reset result: got %h want 00000000", o_result); end
        n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL reset ovf: got %b want 0", o_ovf); end
        n_cmp++; if (o_unf !== 1'b0) begin n_bad++; $display("FAIL reset unf: got %b want 0", o_unf); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", o_in_ready); end
    endtask

    task automatic test_datapath();
        vec_t v[$];
        bit   ok;
        int   lat;
        exp_t want;
        v.push_back(mk("normalised",    1'b0, 8'h80, 28'h4000000, 32'h40000000, 1'b0, 1'b0, 3));
        v.push_back(mk("carry",         1'b0, 8'h7F, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3));
        v.push_back(mk("carry_sticky",  1'b0, 8'h7F, 28'h8000003, 32'h40000000, 1'b0, 1'b0, 3));
        v.push_back(mk("carry_round",   1'b0, 8'h7F, 28'h800000C, 32'h40000001, 1'b0, 1'b0, 3));
        v.push_back(mk("left_shift",    1'b0, 8'h85, 28'h0800000, 32'h41000000, 1'b0, 1'b0, LAT_SH3));
        v.push_back(mk("rne_tie_odd",   1'b0, 8'h7F, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 3));
        v.push_back(mk("rne_tie_even",  1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 3));
        v.push_back(mk("rne_above",     1'b0, 8'h7F, 28'h4000006, 32'h3F800001, 1'b0, 1'b0, 3));
        v.push_back(mk("rne_below",     1'b1, 8'h7F, 28'h4000003, 32'hBF800000, 1'b0, 1'b0, 3));
        foreach (v[i]) begin
            sb.push_back(v[i].want);
            accept_op(v[i].sign, v[i].exp, v[i].man, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; void'(sb.pop_back());
                $display("FAIL %s accept: in_ready stayed low", v[i].name);
                continue;
            end
            wait_valid(lat, ok);
            want = sb.pop_front();
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL %s timeout: out_valid never rose", v[i].name);
                continue;
            end
            n_cmp++; if (o_result !== want.result) begin n_bad++; $display("FAIL %s result: got %h want %h", v[i].name, o_result, want.result); end
            n_cmp++; if (o_ovf !== want.ovf) begin n_bad++; $display("FAIL %s ovf: got %b want %b", v[i].name, o_ovf, want.ovf); end
            n_cmp++; if (o_unf !== want.unf) begin n_bad++; $display("FAIL %s unf: got %b want %b", v[i].name, o_unf, want.unf); end
            n_cmp++; if (lat !== want.lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, want.lat); end
            release_out();
            @(negedge i_clk);
            n_cmp++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin n_bad++; $display("FAIL %s handshake: got valid=%b ready=%b want valid=0 ready=1", v[i].name, o_out_valid, o_in_ready); end
        end
    endtask

    task automatic test_edge_cases();
        vec_t v[$];
        bit   ok;
        int   lat;
        exp_t want;
        v.push_back(mk("ovf_carry",     1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 3));
        v.push_back(mk("ovf_round",     1'b0, 8'hFE, 28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b0, 3));
        v.push_back(mk("inf_input",     1'b1, 8'hFF, 28'h4000000, 32'hFF800000, 1'b1, 1'b0, 1));
        v.push_back(mk("unf_flush",     1'b1, 8'h01, 28'h0000010, 32'h80000000, 1'b0, 1'b1, 2));
        v.push_back(mk("zero_pos",      1'b0, 8'h40, 28'h0000000, 32'h00000000, 1'b0, 1'b0, 2));
        v.push_back(mk("zero_neg",      1'b1, 8'h40, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 2));
        v.push_back(mk("min_normal",    1'b0, 8'h03, 28'h1000000, 32'h00800000, 1'b0, 1'b0, LAT_SH2));
        v.push_back(mk("shift_flush",   1'b0, 8'h02, 28'h1000000, 32'h00000000, 1'b0, 1'b1, LAT_SHFL));
        foreach (v[i]) begin
            sb.push_back(v[i].want);
            accept_op(v[i].sign, v[i].exp, v[i].man, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; void'(sb.pop_back());
                $display("FAIL %s accept: in_ready stayed low", v[i].name);
                continue;
            end
            wait_valid(lat, ok);
            want = sb.pop_front();
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL %s timeout: out_valid never rose", v[i].name);
                continue;
            end
            n_cmp++; if (o_result !== want.result) begin n_bad++; $display("FAIL %s result: got %h want %h", v[i].name, o_result, want.result); end
            n_cmp++; if (o_ovf !== want.ovf) begin n_bad++; $display("FAIL %s ovf: got %b want %b", v[i].name, o_ovf, want.ovf); end
            n_cmp++; if (o_unf !== want.unf) begin n_bad++; $display("FAIL %s unf: got %b want %b", v[i].name, o_unf, want.unf); end
            n_cmp++; if (lat !== want.lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, want.lat); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   lat;
        exp_t want;
        want.result = 32'hC8200000; want.ovf = 1'b0; want.unf = 1'b0; want.lat = 3;
        sb.push_back(want);
        accept_op(1'b1, 8'h90, 28'h5000000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; void'(sb.pop_back());
            $display("FAIL backpressure accept: in_ready stayed low");
            return;
        end
        wait_valid(lat, ok);
        want = sb.pop_front();
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL backpressure timeout: out_valid never rose");
            return;
        end
        n_cmp++; if (o_result !== want.result) begin n_bad++; $display("FAIL backpressure result: got %h want %h", o_result, want.result); end
        // Offer a competing operand while stalled; it must not be taken.
        for (int c = 0; c < 5; c++) begin
            i_in_valid = 1'b1;
            i_sign     = 1'b0;
            i_exp      = 8'h80;
            i_man      = 28'h4000000;
            @(posedge i_clk);
            @(negedge i_clk);
            n_cmp++; if (o_out_valid !== 1'b1) begin n_bad++; $display("FAIL stall%0d out_valid: got %b want 1", c, o_out_valid); end
            n_cmp++; if (o_result !== want.result) begin n_bad++; $display("FAIL stall%0d result: got %h want %h", c, o_result, want.result); end
            n_cmp++; if (o_in_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d in_ready: got %b want 0", c, o_in_ready); end
            n_cmp++; if (o_ovf !== 1'b0 || o_unf !== 1'b0) begin n_bad++; $display("FAIL stall%0d flags: got ovf=%b unf=%b want 0 0", c, o_ovf, o_unf); end
        end
        i_in_valid = 1'b0;
        release_out();
        @(negedge i_clk);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL backpressure drop: got out_valid=%b want 0", o_out_valid); end
    endtask

    task automatic test_reset_mid_op();
        bit   ok;
        int   lat;
        int   seen;
        exp_t want;
        // Left-shift operand keeps the block in NORM for several cycles; it is
        // discarded by the reset, so nothing goes on the scoreboard.
        accept_op(1'b0, 8'h85, 28'h0800000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL reset_mid accept: in_ready stayed low");
            return;
        end
        @(negedge i_clk);
        n_cmp++; if (o_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mid busy: got in_ready=%b want 0", o_in_ready); end
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid out_valid: got %b want 0", o_out_valid); end
        n_cmp++; if (o_result !== 32'h0) begin n_bad++; $display("FAIL reset_mid result: got %h want 00000000", o_result); end
        n_cmp++; if (o_ovf !== 1'b0 || o_unf !== 1'b0) begin n_bad++; $display("FAIL reset_mid flags: got ovf=%b unf=%b want 0 0", o_ovf, o_unf); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid in_ready: got %b want 1", o_in_ready); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (o_out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL reset_mid ghost: got %0d valid cycles want 0", seen); end

        want.result = 32'h40000000; want.ovf = 1'b0; want.unf = 1'b0; want.lat = 3;
        sb.push_back(want);
        accept_op(1'b0, 8'h7F, 28'h8000000, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; void'(sb.pop_back());
            $display("FAIL after_reset accept: in_ready stayed low");
            return;
        end
        wait_valid(lat, ok);
        want = sb.pop_front();
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL after_reset timeout: out_valid never rose");
            return;
        end
        n_cmp++; if (o_result !== want.result) begin n_bad++; $display("FAIL after_reset result: got %h want %h", o_result, want.result); end
        n_cmp++; if (lat !== want.lat) begin n_bad++; $display("FAIL after_reset latency: got %0d want %0d", lat, want.lat); end
        release_out();
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        bit   ok;
        int   lat;
        exp_t want;
        v.push_back(mk("b2b_norm",   1'b1, 8'h80, 28'h4000000, 32'hC0000000, 1'b0, 1'b0, 3));
        v.push_back(mk("b2b_even",   1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 3));
        v.push_back(mk("b2b_zero",   1'b0, 8'h10, 28'h0000000, 32'h00000000, 1'b0, 1'b0, 2));
        v.push_back(mk("b2b_shift",  1'b0, 8'h85, 28'h0800000, 32'h41000000, 1'b0, 1'b0, LAT_SH3));
        v.push_back(mk("b2b_ovf",    1'b1, 8'hFE, 28'h8000000, 32'hFF800000, 1'b1, 1'b0, 3));
        // Downstream always ready: each result is consumed on the edge after it appears.
        i_out_ready = 1'b1;
        foreach (v[i]) begin
            sb.push_back(v[i].want);
            accept_op(v[i].sign, v[i].exp, v[i].man, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; void'(sb.pop_back());
                $display("FAIL %s accept: in_ready stayed low", v[i].name);
                continue;
            end
            wait_valid(lat, ok);
            want = sb.pop_front();
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL %s timeout: out_valid never rose", v[i].name);
                continue;
            end
            n_cmp++; if (o_result !== want.result) begin n_bad++; $display("FAIL %s result: got %h want %h", v[i].name, o_result, want.result); end
            n_cmp++; if (o_ovf !== want.ovf || o_unf !== want.unf) begin n_bad++; $display("FAIL %s flags: got ovf=%b unf=%b want %b %b", v[i].name, o_ovf, o_unf, want.ovf, want.unf); end
            n_cmp++; if (lat !== want.lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, want.lat); end
        end
        @(negedge i_clk);
        i_out_ready = 1'b0;
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard drain: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_sign      = 1'b0;
        i_exp       = 8'h00;
        i_man       = 28'h0;
        i_out_ready = 1'b0;

        test_reset();
        test_datapath();
        test_edge_cases();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
